lpf_seq_ctrl: RTL and testbench

Sample sequencer for the 8-bit low-pass filter datapath. On a start pulse it fetches a programmed number of 8-bit samples from a synchronous-read sample memory and presents them to the filter at a programmable rate. It then captures each filtered result after the filter's fixed pipeline latency and signals completion. It sits between the sample buffer and the `lpf` instance and replaces free-running stimulus feeding.

---
 rtl/lpf_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lpf_seq_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lpf_seq_ctrl.sv
// Sample sequencer feeding the lpf datapath from a synchronous-read sample memory.
// Optional macro LPF_SEQ_LOOP_EN adds loop_en/wrap for continuous cyclic playback.
module lpf_seq_ctrl #(
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DEPTH   = 101,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned LPF_LAT = 3
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_samp,
  input  logic [DIV_W-1:0]  rate_div,
`ifdef LPF_SEQ_LOOP_EN
  input  logic              loop_en,
  output logic              wrap,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        lpf_in,
  output logic              lpf_in_vld,
  input  logic [7:0]        lpf_out,
  output logic [7:0]        res_dat,
  output logic              res_vld,
  output logic              busy,
  output logic              done
);

  localparam int unsigned VLD_W = LPF_LAT + 3;
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [VLD_W-1:0]    vld_q, vld_d;
  logic [7:0]          lpf_in_q, lpf_in_d;
  logic                lpf_in_vld_q, lpf_in_vld_d;
  logic [7:0]          res_dat_q, res_dat_d;
  logic                res_vld_q, res_vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick_c;
  logic                loop_c;
  logic [ADDR_W:0]     n_c;

`ifdef LPF_SEQ_LOOP_EN
  logic                wrap_q, wrap_d;
  assign loop_c = loop_en;
  assign wrap   = wrap_q;
`else
  assign loop_c = 1'b0;
`endif

  assign n_c = (num_samp > DEPTH_N) ? DEPTH_N : num_samp;

  // Pass control, rate divider and the in-flight valid pipeline
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    last_d     = last_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    tick_c     = 1'b0;
    done_d     = 1'b0;
`ifdef LPF_SEQ_LOOP_EN
    wrap_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = RUN;
            mem_addr_d = '0;
            last_d     = ADDR_W'(n_c - (ADDR_W + 1)'(1));
            div_d      = rate_div;
            cnt_d      = rate_div;
            tick_c     = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - DIV_W'(1);
        // Decide at the final tick whether the pass ends or wraps
        if (vld_q[0] && (mem_addr_q == last_q) && !loop_c) begin
          state_d = DRAIN;
        end else if (cnt_q == '0) begin
          tick_c = 1'b1;
          cnt_d  = div_q;
          if (mem_addr_q == last_q) begin
            mem_addr_d = '0;
`ifdef LPF_SEQ_LOOP_EN
            wrap_d     = 1'b1;
`endif
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (vld_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      tick_c  = 1'b0;
      done_d  = 1'b0;
`ifdef LPF_SEQ_LOOP_EN
      wrap_d  = 1'b0;
`endif
    end

    vld_d        = abort ? '0 : {vld_q[VLD_W-2:0], tick_c};
    lpf_in_vld_d = vld_q[1] && !abort;
    lpf_in_d     = lpf_in_vld_d ? mem_rdata : lpf_in_q;
    res_vld_d    = vld_q[VLD_W-1] && !abort;
    res_dat_d    = res_vld_d ? lpf_out : res_dat_q;
    busy_d       = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      last_q       <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      vld_q        <= '0;
      lpf_in_q     <= '0;
      lpf_in_vld_q <= 1'b0;
      res_dat_q    <= '0;
      res_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef LPF_SEQ_LOOP_EN
      wrap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      last_q       <= last_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      vld_q        <= vld_d;
      lpf_in_q     <= lpf_in_d;
      lpf_in_vld_q <= lpf_in_vld_d;
      res_dat_q    <= res_dat_d;
      res_vld_q    <= res_vld_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef LPF_SEQ_LOOP_EN
      wrap_q       <= wrap_d;
`endif
    end
  end

  assign mem_addr   = mem_addr_q;
  assign lpf_in     = lpf_in_q;
  assign lpf_in_vld = lpf_in_vld_q;
  assign res_dat    = res_dat_q;
  assign res_vld    = res_vld_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lpf_seq_ctrl.sv
// Directed bench for lpf_seq_ctrl with a sample-memory model and a 3-stage filter model.
module tb_lpf_seq_ctrl;

  localparam int DEPTH   = 101;
  localparam int LPF_LAT = 3;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] num_samp;
  logic [7:0] rate_div;
  logic [6:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] lpf_in;
  logic       lpf_in_vld;
  logic [7:0] lpf_out;
  logic [7:0] res_dat;
  logic       res_vld;
  logic       busy;
  logic       done;

  logic [7:0] mem [0:127];
  logic [7:0] p1, p2, p3;
  logic [7:0] exp_in;
  int         n_checks = 0;
  int         n_fail   = 0;

  lpf_seq_ctrl dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .num_samp   (num_samp),
    .rate_div   (rate_div),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .lpf_in     (lpf_in),
    .lpf_in_vld (lpf_in_vld),
    .lpf_out    (lpf_out),
    .res_dat    (res_dat),
    .res_vld    (res_vld),
    .busy       (busy),
    .done       (done)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous-read memory and a fixed-latency filter stand-in (output = ~input)
  always @(posedge sys_clk) begin
    mem_rdata <= mem[mem_addr];
    p1        <= ~lpf_in;
    p2        <= p1;
    p3        <= p2;
  end
  assign lpf_out = p3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int tick_idx(input int c, input int d, input int nn);
    if (c < 1 || nn == 0) return -1;
    if ((c - 1) % (d + 1) != 0) return -1;
    if ((c - 1) / (d + 1) >= nn) return -1;
    return (c - 1) / (d + 1);
  endfunction

  // Starts a pass in the current cycle (cycle 0) and checks ncyc following cycles
  task automatic run_pass(input string nm, input int n, input int d, input int abort_at,
                          input int start2_at, input int ncyc,
                          output int done_c, output int nres);
    int nn, last_res, k, ki, kr;
    bit alive, eb, ed, ei, er;
    logic [7:0] r8;
    nn       = (n > DEPTH) ? DEPTH : n;
    last_res = (nn > 0) ? 1 + (nn - 1) * (d + 1) + LPF_LAT + 3 : 0;
    done_c   = -1;
    nres     = 0;
    start    = 1'b1;
    num_samp = 8'(n);
    rate_div = 8'(d);
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start = (c == start2_at);
      abort = (c == abort_at);
      if (c == start2_at) num_samp = 8'd2;
      alive = (abort_at < 0) || (c <= abort_at);
      ki = tick_idx(c - 2, d, nn);
      kr = tick_idx(c - LPF_LAT - 3, d, nn);
      k  = tick_idx(c, d, nn);
      eb = alive && (nn > 0) && (c <= last_res);
      ed = alive && (c == last_res + 1);
      ei = alive && (ki >= 0);
      er = alive && (kr >= 0);
      check($sformatf("%s_ctl@%0d", nm, c), 32'({busy, done, lpf_in_vld, res_vld}),
            32'({eb, ed, ei, er}));
      if (alive && k >= 0) check($sformatf("%s_addr@%0d", nm, c), 32'(mem_addr), 32'(k));
      if (ei) exp_in = mem[ki];
      check($sformatf("%s_in@%0d", nm, c), 32'(lpf_in), 32'(exp_in));
      if (er) begin
        r8 = ~mem[kr];
        check($sformatf("%s_res@%0d", nm, c), 32'(res_dat), 32'(r8));
      end
      if (done && done_c < 0) done_c = c;
      if (res_vld) nres++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int dc, nr;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 3 + 8'h80);
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    rst = 1'b0; start = 1'b0; abort = 1'b0; num_samp = '0; rate_div = '0;
    exp_in = '0;
    repeat (3) step();
    check("reset_state", 32'({mem_addr, lpf_in, lpf_in_vld, res_dat, res_vld, busy, done}), 32'(0));
    rst = 1'b1;
    step();

    run_pass("p1", 4, 0, -1, -1, 12, dc, nr);
    check("p1_done_cyc", 32'(dc), 32'(11));
    check("p1_nres", 32'(nr), 32'(4));

    run_pass("p2", 3, 2, -1, -1, 15, dc, nr);
    check("p2_done_cyc", 32'(dc), 32'(14));
    check("p2_nres", 32'(nr), 32'(3));

    run_pass("p3", 0, 0, -1, -1, 3, dc, nr);
    check("p3_done_cyc", 32'(dc), 32'(1));

    run_pass("p4", 4, 0, 5, -1, 8, dc, nr);
    check("p4_no_done", 32'(dc), 32'(-1));
    check("p4_nres", 32'(nr), 32'(0));

    run_pass("p5", 4, 0, -1, -1, 12, dc, nr);
    check("p5_done_cyc", 32'(dc), 32'(11));

    run_pass("p6", 200, 0, -1, 50, 109, dc, nr);
    check("p6_done_cyc", 32'(dc), 32'(108));
    check("p6_nres", 32'(nr), 32'(101));

    // Reset asserted mid-run
    start = 1'b1; num_samp = 8'd4; rate_div = 8'd0;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'(1));
    rst = 1'b0;
    step();
    check("rst_outs", 32'({mem_addr, lpf_in, lpf_in_vld, res_dat, res_vld, busy, done}), 32'(0));
    rst = 1'b1;
    exp_in = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("post_rst_idle@%0d", i), 32'({busy, done, lpf_in_vld, res_vld}), 32'(0));
    end

    run_pass("p7", 2, 1, -1, -1, 11, dc, nr);
    check("p7_done_cyc", 32'(dc), 32'(10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
